// File: rtl/mem_wb_stage.sv
// MEM/WB boundary: load alignment/extension, writeback select, stall/flush control
// and register-file / forwarding outputs. Optional retire counter: MEM_WB_RETIRE_CNT_EN.

module mem_wb_load_align #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      load_type,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // misaligned halfwords still use off[1]; misaligned words ignore off
        half_sel = off[1] ? word[31:16] : word[15:0];

        data       = word;
        misaligned = 1'b0;
        case (load_type)
            3'b000: data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100: data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001: begin
                data       = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            3'b101: begin
                data       = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = off[0];
            end
            default: misaligned = |off;
        endcase
    end
endmodule

module mem_wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic [2:0]            LoadType,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       Mem_out,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  fwd_en,
    output logic                  misalign_err,
    output logic [31:0]           retire_count
);
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  misalign;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    wb_entry_t       wb_q, wb_d;
    logic [XLEN-1:0] load_data;
    logic            load_misaligned;

    mem_wb_load_align #(.XLEN(XLEN)) u_align (
        .load_type  (LoadType),
        .off        (alu_result[1:0]),
        .word       (Mem_out),
        .data       (load_data),
        .misaligned (load_misaligned)
    );

    always_comb begin
        wb_d          = '0;
        wb_d.valid    = in_valid;
        wb_d.we       = in_valid & RegWrite & (rd_in != '0);
        wb_d.misalign = in_valid & MemtoReg & load_misaligned;
        wb_d.rd       = rd_in;
        wb_d.data     = MemtoReg ? load_data : alu_result;
    end

    // flush beats stall: a squashed entry must never linger in WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       wb_q <= '0;
        else if (flush)   wb_q <= '0;
        else if (!stall)  wb_q <= wb_d;
    end

    assign wb_valid     = wb_q.valid;
    assign wb_we        = wb_q.we;
    assign wb_rd        = wb_q.rd;
    assign wb_data      = wb_q.data;
    assign misalign_err = wb_q.misalign;
    assign fwd_en       = wb_q.we;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          retire_q <= '0;
        else if (!flush && !stall && in_valid) retire_q <= retire_q + 32'd1;
    end

    assign retire_count = retire_q;
`else
    assign retire_count = 32'd0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: load extraction, ALU path, stall/flush,
// async reset and the optional retire counter.

module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic        RegWrite = 1'b0, MemtoReg = 1'b0;
    logic [2:0]  LoadType = 3'd0;
    logic [31:0] alu_result = '0, Mem_out = '0;
    logic [4:0]  rd_in = '0;
    logic        wb_valid, wb_we, fwd_en, misalign_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .LoadType(LoadType),
        .alu_result(alu_result), .Mem_out(Mem_out), .rd_in(rd_in),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_en(fwd_en), .misalign_err(misalign_err), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        fwd;
        logic        mis;
        logic [4:0]  rd;
        logic [31:0] data;
    } obs_t;

    obs_t exp_q[$];
    obs_t last_exp;

    function automatic obs_t mk(logic v, logic we, logic mis, logic [4:0] rd, logic [31:0] d);
        obs_t o;
        o = {v, we, we, mis, rd, d};
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {wb_valid, wb_we, fwd_en, misalign_err, wb_rd, wb_data};
        return o;
    endfunction

    task automatic set_in(input logic iv, input logic rw, input logic m2r, input logic [2:0] lt,
                          input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd);
        in_valid = iv; RegWrite = rw; MemtoReg = m2r; LoadType = lt;
        alu_result = alu; Mem_out = mem; rd_in = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        #12;
        got = sample();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=%h", got, obs_t'(0));
        end
        n_cmp++;
        if (retire_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_retire got=%h want=0", retire_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] data;
        logic        mis;
    } lv_t;

    task automatic test_load_extract();
        lv_t  lv[15];
        obs_t got, e;
        lv = '{
            '{3'b000, 32'h1003, 32'h80FF7F01, 32'hFFFFFF80, 1'b0},
            '{3'b100, 32'h1003, 32'h80FF7F01, 32'h00000080, 1'b0},
            '{3'b000, 32'h1000, 32'h80FF7F01, 32'h00000001, 1'b0},
            '{3'b000, 32'h1001, 32'h80FF7F01, 32'h0000007F, 1'b0},
            '{3'b100, 32'h1002, 32'h80FF7F01, 32'h000000FF, 1'b0},
            '{3'b001, 32'h2002, 32'h80011234, 32'hFFFF8001, 1'b0},
            '{3'b001, 32'h2001, 32'h80011234, 32'h00001234, 1'b1},
            '{3'b101, 32'h2002, 32'h80011234, 32'h00008001, 1'b0},
            '{3'b001, 32'h2000, 32'h80FF7F01, 32'h00007F01, 1'b0},
            '{3'b101, 32'h2003, 32'h80FF7F01, 32'h000080FF, 1'b1},
            '{3'b010, 32'h3000, 32'h80011234, 32'h80011234, 1'b0},
            '{3'b010, 32'h3002, 32'h80011234, 32'h80011234, 1'b1},
            '{3'b110, 32'h3000, 32'h80FF7F01, 32'h80FF7F01, 1'b0},
            '{3'b111, 32'h3001, 32'h80FF7F01, 32'h80FF7F01, 1'b1},
            '{3'b011, 32'h3004, 32'h80FF7F01, 32'h80FF7F01, 1'b0}
        };
        for (int i = 0; i < 15; i++) begin
            set_in(1'b1, 1'b1, 1'b1, lv[i].lt, lv[i].alu, lv[i].mem, 5'(i + 1));
            exp_q.push_back(mk(1'b1, 1'b1, lv[i].mis, 5'(i + 1), lv[i].data));
            tick();
            got = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL load_extract[%0d] got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_alu_path();
        obs_t got, e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    set_in(1'b1, 1'b1, 1'b0, 3'b010, 32'hDEADBEEF, 32'h11111111, 5'd0);
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF));
                end
                1: begin
                    set_in(1'b1, 1'b1, 1'b0, 3'b010, 32'h00000003, 32'h22222222, 5'd9);
                    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 5'd9, 32'h00000003));
                end
                2: begin
                    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h00000001, 32'hCAFEF00D, 5'd7);
                    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 5'd7, 32'hCAFEF00D));
                end
                default: begin
                    set_in(1'b1, 1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 5'd31);
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 5'd31, 32'h12345678));
                end
            endcase
            tick();
            got = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL alu_path[%0d] got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_stall_flush();
        obs_t got, e;
        set_in(1'b1, 1'b1, 1'b1, 3'b001, 32'h00002001, 32'h80011234, 5'd12);
        last_exp = mk(1'b1, 1'b1, 1'b1, 5'd12, 32'h00001234);
        exp_q.push_back(last_exp);
        tick();
        got = sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL stall_setup got=%h want=%h", got, e);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'($urandom_range(1)), 3'($urandom_range(7)),
                   $urandom, $urandom, 5'($urandom_range(1, 31)));
            exp_q.push_back(last_exp);
            tick();
            got = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL stall_hold[%0d] got=%h want=%h", i, got, e);
            end
        end
        flush = 1'b1;
        exp_q.push_back(obs_t'(0));
        tick();
        got = sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL flush_over_stall got=%h want=%h", got, e);
        end
        stall = 1'b0; flush = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 3'b000, 32'h0BADC0DE, 32'h0, 5'd4);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 5'd4, 32'h0BADC0DE));
        tick();
        got = sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL resume_after_flush got=%h want=%h", got, e);
        end
        flush = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 3'b010, 32'h00000002, 32'hFFFFFFFF, 5'd6);
        exp_q.push_back(obs_t'(0));
        tick();
        got = sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL flush_only got=%h want=%h", got, e);
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t got, e;
        set_in(1'b1, 1'b1, 1'b0, 3'b010, 32'hA5A5A5A5, 32'h0, 5'd17);
        tick();
        #2 rst_n = 1'b0;
        #1;
        got = sample();
        n_cmp++;
        if (got !== obs_t'(0) || retire_count !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset got=%h cnt=%h want=0", got, retire_count);
        end
        #1 rst_n = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 3'b100, 32'h00000001, 32'h0000C300, 5'd3);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 5'd3, 32'h000000C3));
        tick();
        got = sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL first_after_reset got=%h want=%h", got, e);
        end
    endtask

    task automatic test_retire_count();
        logic [31:0] want_mid, want_end;
`ifdef MEM_WB_RETIRE_CNT_EN
        want_mid = 32'd5;
        want_end = 32'd10;
`else
        want_mid = 32'd0;
        want_end = 32'd0;
`endif
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            stall = (i == 3) || (i == 7);
            flush = (i == 10);
            set_in(1'b1, 1'b1, 1'b0, 3'b010, 32'(i), 32'h0, 5'd1);
            tick();
            if (i == 5) begin
                n_cmp++;
                if (retire_count !== want_mid) begin
                    n_bad++;
                    $display("FAIL retire_mid got=%0d want=%0d", retire_count, want_mid);
                end
            end
        end
        stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd1);
            tick();
        end
        n_cmp++;
        if (retire_count !== want_end) begin
            n_bad++;
            $display("FAIL retire_end got=%0d want=%0d", retire_count, want_end);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_extract();
        test_alu_path();
        test_stall_flush();
        test_async_reset();
        test_retire_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
